// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants and types for the divide controller.
//   - RV32M divide funct3 codes
//   - register bus / address widths
//   - one-hot FSM state constants
//   - latched divide request record
package div_ctrl_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_WAIT = 4'b0010;
  localparam logic [3:0] S_CALC = 4'b0100;
  localparam logic [3:0] S_WB   = 4'b1000;

  typedef struct packed {
    logic [2:0]            op;
    logic [REG_W-1:0]      dividend;
    logic [REG_W-1:0]      divisor;
    logic [REG_ADDR_W-1:0] rd;
  } div_req_t;

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: request/response channel between div_ctrl and the divider.
//   master (div_ctrl): drives start/op/operands/waddr, receives result/ready/busy/waddr
//   slave  (divider) : the reverse
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                  div_start_o;
  logic [2:0]            div_op_o;
  logic [REG_W-1:0]      div_dividend_o;
  logic [REG_W-1:0]      div_divisor_o;
  logic [REG_ADDR_W-1:0] div_reg_waddr_o;
  logic [REG_W-1:0]      div_result_i;
  logic                  div_ready_i;
  logic                  div_busy_i;
  logic [REG_ADDR_W-1:0] div_reg_waddr_i;

  modport master (
    output div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_reg_waddr_o,
    input  div_result_i, div_ready_i, div_busy_i, div_reg_waddr_i
  );

  modport slave (
    input  div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_reg_waddr_o,
    output div_result_i, div_ready_i, div_busy_i, div_reg_waddr_i
  );

endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for DIV/DIVU/REM/REMU on an external divider.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_i, op_i         divide instruction present in EX, funct3
//   rs1/rs2_data_i      dividend / divisor, rd_addr_i destination
//   flush_i             kill any divide in progress (except in WB)
//   div_bus (master)    request to / response from the divider
//   hold_flag_o         stall stages in front of EX
//   reg_we/waddr/wdata  register-file write port
//   timeout_o           watchdog abort pulse
//   waddr_err_o         divider returned a different rd than latched
//
// state | meaning
// IDLE  | no divide outstanding, accepts a new request
// WAIT  | request latched, divider still busy with previous work
// CALC  | divider running, start held, watchdog counting
// WB    | one-cycle register-file write of the captured result
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WDT_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [2:0]            op_i,
  input  logic [REG_W-1:0]      rs1_data_i,
  input  logic [REG_W-1:0]      rs2_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  flush_i,
  div_ctrl_if.master            div_bus,
  output logic                  hold_flag_o,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [REG_W-1:0]      reg_wdata_o,
  output logic                  timeout_o,
  output logic                  waddr_err_o
);

  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  logic [3:0]       state, state_nxt;
  div_req_t         req_q;
  logic [REG_W-1:0] result_q;
  logic [WDT_W-1:0] wdt_cnt;
  logic             timeout_q;
  logic             waddr_err_q;

  logic in_idle, in_wait, in_calc, in_wb;
  logic wdt_expire;

  assign in_idle = (state == S_IDLE);
  assign in_wait = (state == S_WAIT);
  assign in_calc = (state == S_CALC);
  assign in_wb   = (state == S_WB);

  // wdt_cnt is 0 in the first CALC cycle, so the last allowed cycle sees LIMIT-1
  assign wdt_expire = (wdt_cnt == WDT_W'(WDT_LIMIT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_i && !flush_i) state_nxt = div_bus.div_busy_i ? S_WAIT : S_CALC;
      S_WAIT: begin
        if (flush_i)                  state_nxt = S_IDLE;
        else if (!div_bus.div_busy_i) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (flush_i)                  state_nxt = S_IDLE;
        else if (div_bus.div_ready_i) state_nxt = S_WB;
        else if (wdt_expire)          state_nxt = S_IDLE;
      end
      S_WB:    state_nxt = S_IDLE;  // flush ignored: instruction already retired
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_q       <= '0;
      result_q    <= ZERO_WORD;
      wdt_cnt     <= '0;
      timeout_q   <= 1'b0;
      waddr_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_q   <= 1'b0;
      waddr_err_q <= 1'b0;

      if (in_idle && req_i && !flush_i)
        req_q <= '{op: op_i, dividend: rs1_data_i, divisor: rs2_data_i, rd: rd_addr_i};

      if (state_nxt == S_CALC && !in_calc) wdt_cnt <= '0;
      else if (in_calc)                    wdt_cnt <= wdt_cnt + 1'b1;

      // a ready seen in a flush cycle is discarded
      if (in_calc && !flush_i) begin
        if (div_bus.div_ready_i) begin
          result_q    <= div_bus.div_result_i;
          waddr_err_q <= (div_bus.div_reg_waddr_i != req_q.rd);
        end else if (wdt_expire) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  // start is never high alongside ready, so the divider cannot restart on completion
  assign div_bus.div_start_o     = ~rst & in_calc & ~div_bus.div_ready_i & ~flush_i;
  assign div_bus.div_op_o        = rst ? 3'b000    : req_q.op;
  assign div_bus.div_dividend_o  = rst ? ZERO_WORD : req_q.dividend;
  assign div_bus.div_divisor_o   = rst ? ZERO_WORD : req_q.divisor;
  assign div_bus.div_reg_waddr_o = rst ? '0        : req_q.rd;

  assign hold_flag_o = ~rst & ((req_i & ~flush_i & in_idle) | in_wait | in_calc);

  // x0 is hardwired: suppress the strobe but keep the WB cycle
  assign reg_we_o    = ~rst & in_wb & (req_q.rd != '0);
  assign reg_waddr_o = (~rst & in_wb) ? req_q.rd : '0;
  assign reg_wdata_o = (~rst & in_wb) ? result_q : ZERO_WORD;
  assign timeout_o   = ~rst & timeout_q;
  assign waddr_err_o = ~rst & waddr_err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed test of div_ctrl against a behavioural divider stub
// (35-cycle latency for a nonzero divisor, 2 for a zero divisor, abort when start drops).
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        hold_flag_o, reg_we_o, timeout_o, waddr_err_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  logic        ext_busy = 1'b0;
  logic        stub_hang = 1'b0;
  logic        bad_waddr = 1'b0;

  logic        stub_busy;
  logic [5:0]  stub_cnt;
  logic [31:0] stub_res;
  logic [4:0]  stub_waddr;

  int n_checks = 0;
  int n_fail = 0;
  int we_cnt = 0, start_cnt = 0, both_cnt = 0, to_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [4:0]  last_waddr = '0;

  div_ctrl_if bus ();

  div_ctrl #(.WDT_LIMIT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .op_i        (op_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .div_bus     (bus.master),
    .hold_flag_o (hold_flag_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o),
    .timeout_o   (timeout_o),
    .waddr_err_o (waddr_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] div_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'b100:  r = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      3'b101:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  r = (b == 0) ? a : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // divider stub
  always @(posedge clk) begin
    if (rst) begin
      stub_busy  <= 1'b0;
      stub_cnt   <= '0;
      stub_res   <= '0;
      stub_waddr <= '0;
    end else if (!stub_busy) begin
      if (bus.div_start_o) begin
        stub_busy  <= 1'b1;
        stub_cnt   <= (bus.div_divisor_o == 0) ? 6'd1 : 6'd34;
        stub_res   <= div_model(bus.div_op_o, bus.div_dividend_o, bus.div_divisor_o);
        stub_waddr <= bus.div_reg_waddr_o;
      end
    end else if (!bus.div_start_o) begin
      stub_busy <= 1'b0;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1'b1;
    end
  end

  assign bus.div_ready_i     = stub_busy && (stub_cnt == 6'd1) && !stub_hang;
  assign bus.div_busy_i      = stub_busy | ext_busy;
  assign bus.div_result_i    = stub_res;
  assign bus.div_reg_waddr_i = bad_waddr ? (stub_waddr ^ 5'd1) : stub_waddr;

  always @(negedge clk) begin
    if (reg_we_o) begin
      we_cnt <= we_cnt + 1;
      last_wdata <= reg_wdata_o;
      last_waddr <= reg_waddr_o;
    end
    if (bus.div_start_o) start_cnt <= start_cnt + 1;
    if (bus.div_start_o && bus.div_ready_i) both_cnt <= both_cnt + 1;
    if (timeout_o) to_cnt <= to_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // returns at the negedge of the first CALC (or WAIT) cycle
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    req_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic wait_we(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (reg_we_o !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_we_seen"}, {31'd0, reg_we_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cyc, we0, st0, both0, to0;

    // reset
    repeat (3) @(negedge clk);
    check_val("rst_start",   {31'd0, bus.div_start_o}, 32'd0);
    check_val("rst_we",      {31'd0, reg_we_o}, 32'd0);
    check_val("rst_hold",    {31'd0, hold_flag_o}, 32'd0);
    check_val("rst_wdata",   reg_wdata_o, 32'd0);
    check_val("rst_dividend", bus.div_dividend_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DIV 100/7 rd=5
    we0 = we_cnt; st0 = start_cnt; both0 = both_cnt;
    issue(INST_DIV, 32'd100, 32'd7, 5'd5);
    check_val("div_start_c1", {31'd0, bus.div_start_o}, 32'd1);
    check_val("div_dividend", bus.div_dividend_o, 32'd100);
    check_val("div_divisor",  bus.div_divisor_o, 32'd7);
    check_val("div_op",       {29'd0, bus.div_op_o}, {29'd0, INST_DIV});
    check_val("div_waddr",    {27'd0, bus.div_reg_waddr_o}, 32'd5);
    check_val("div_hold_calc", {31'd0, hold_flag_o}, 32'd1);
    wait_we("div", 100, cyc);
    check_val("div_lat",   cyc, 32'd35);
    check_val("div_wdata", reg_wdata_o, 32'd14);
    check_val("div_wreg",  {27'd0, reg_waddr_o}, 32'd5);
    check_val("div_hold_wb", {31'd0, hold_flag_o}, 32'd0);
    @(negedge clk);
    check_val("div_we_once",  we_cnt - we0, 32'd1);
    check_val("div_we_low",   {31'd0, reg_we_o}, 32'd0);
    check_val("div_start_cnt", start_cnt - st0, 32'd34);

    // REM -7,2 / DIV -7,2 / DIVU 9/0
    issue(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_we("rem_neg", 100, cyc);
    check_val("rem_neg", reg_wdata_o, 32'hFFFF_FFFF);
    issue(INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
    wait_we("div_neg", 100, cyc);
    check_val("div_neg", reg_wdata_o, 32'hFFFF_FFFD);
    issue(INST_DIVU, 32'd9, 32'd0, 5'd8);
    wait_we("divu0", 10, cyc);
    check_val("divu0", reg_wdata_o, 32'hFFFF_FFFF);
    check_val("divu0_lat", cyc, 32'd2);

    // flush 10 cycles into CALC
    @(negedge clk);
    we0 = we_cnt;
    issue(INST_DIV, 32'd100, 32'd7, 5'd9);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check_val("flush_start", {31'd0, bus.div_start_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    check_val("flush_busy", {31'd0, bus.div_busy_i}, 32'd0);
    check_val("flush_hold", {31'd0, hold_flag_o}, 32'd0);
    repeat (40) @(negedge clk);
    check_val("flush_no_we", we_cnt - we0, 32'd0);
    issue(INST_DIV, 32'd8, 32'd2, 5'd10);
    wait_we("after_flush", 100, cyc);
    check_val("after_flush", reg_wdata_o, 32'd4);

    // back-to-back DIV then REM
    both0 = both_cnt;
    issue(INST_DIV, 32'd100, 32'd7, 5'd11);
    wait_we("b2b_div", 100, cyc);
    check_val("b2b_div", reg_wdata_o, 32'd14);
    issue(INST_REM, 32'd100, 32'd7, 5'd12);
    wait_we("b2b_rem", 100, cyc);
    check_val("b2b_rem", reg_wdata_o, 32'd2);
    check_val("b2b_rem_wreg", {27'd0, reg_waddr_o}, 32'd12);
    @(negedge clk);
    check_val("start_with_ready", both_cnt - both0, 32'd0);

    // divider busy at issue -> WAIT_FREE
    ext_busy = 1'b1;
    issue(INST_DIVU, 32'd8, 32'd2, 5'd13);
    check_val("wait_hold",  {31'd0, hold_flag_o}, 32'd1);
    check_val("wait_start", {31'd0, bus.div_start_o}, 32'd0);
    @(negedge clk);
    check_val("wait_start2", {31'd0, bus.div_start_o}, 32'd0);
    ext_busy = 1'b0;
    @(negedge clk);
    check_val("wait_to_calc", {31'd0, bus.div_start_o}, 32'd1);
    wait_we("wait", 100, cyc);
    check_val("wait_wdata", reg_wdata_o, 32'd4);

    // watchdog
    @(negedge clk);
    stub_hang = 1'b1;
    we0 = we_cnt; st0 = start_cnt; to0 = to_cnt;
    issue(INST_DIV, 32'd8, 32'd2, 5'd14);
    cyc = 0;
    while (timeout_o !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("wdt_seen", {31'd0, timeout_o}, 32'd1);
    check_val("wdt_cycles", cyc, 32'd64);
    check_val("wdt_hold", {31'd0, hold_flag_o}, 32'd0);
    check_val("wdt_start_cnt", start_cnt - st0, 32'd64);
    @(negedge clk);
    stub_hang = 1'b0;
    check_val("wdt_pulse", {31'd0, timeout_o}, 32'd0);
    check_val("wdt_to_once", to_cnt - to0, 32'd1);
    check_val("wdt_no_we", we_cnt - we0, 32'd0);

    // divider returns wrong rd
    bad_waddr = 1'b1;
    issue(INST_DIV, 32'd8, 32'd2, 5'd14);
    wait_we("werr", 100, cyc);
    check_val("werr_pulse", {31'd0, waddr_err_o}, 32'd1);
    check_val("werr_wreg",  {27'd0, reg_waddr_o}, 32'd14);
    check_val("werr_wdata", reg_wdata_o, 32'd4);
    @(negedge clk);
    bad_waddr = 1'b0;
    check_val("werr_clear", {31'd0, waddr_err_o}, 32'd0);

    // rd = 0
    we0 = we_cnt;
    issue(INST_DIV, 32'd8, 32'd2, 5'd0);
    repeat (40) @(negedge clk);
    check_val("rd0_no_we", we_cnt - we0, 32'd0);
    check_val("rd0_idle",  {31'd0, hold_flag_o}, 32'd0);

    // reset mid-CALC
    we0 = we_cnt;
    issue(INST_DIV, 32'd100, 32'd7, 5'd15);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_mid_start", {31'd0, bus.div_start_o}, 32'd0);
    @(negedge clk);
    check_val("rstm_start",    {31'd0, bus.div_start_o}, 32'd0);
    check_val("rstm_dividend", bus.div_dividend_o, 32'd0);
    check_val("rstm_divisor",  bus.div_divisor_o, 32'd0);
    check_val("rstm_waddr",    {27'd0, bus.div_reg_waddr_o}, 32'd0);
    check_val("rstm_hold",     {31'd0, hold_flag_o}, 32'd0);
    check_val("rstm_we",       {31'd0, reg_we_o}, 32'd0);
    check_val("rstm_timeout",  {31'd0, timeout_o}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_val("rstm_no_we", we_cnt - we0, 32'd0);
    check_val("rstm_hold_after", {31'd0, hold_flag_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
